// File: rtl/ifetch32.sv
// ifetch32: instruction fetch / PC unit feeding the instruction decoder.
// Owns the fetch PC and the fetch/decode pipeline register (ir, ir_pc).
// After a taken branch it squashes the fall-through slot. For BL it
// generates the r14 link write.
// Optional build macro IFETCH_PERF_EN enables the fetch and taken-branch
// performance counters. Without it both counter ports read as zero.
module ifetch32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  output logic [31:0] imem_addr_out,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] iin_out,
  output logic        ispb_out,
  input  logic        ib_in,
  input  logic [31:0] bv_in,
  input  logic        bl_in,
  output logic [31:0] pc_out,
  output logic        link_we_out,
  output logic [31:0] link_val_out,
  output logic [31:0] perf_fetch_out,
  output logic [31:0] perf_branch_out
);

  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        squash;

  logic        advance;
  logic        take_branch;
  logic [31:0] pc_next;

  // A branch is honoured only on an advancing edge outside a squash shadow.
  // The decoder already gates ib with ispb; masking it here as well keeps a
  // stray ib from redirecting fetch or writing r14.
  assign advance     = ~stall_in;
  assign take_branch = advance & ib_in & ~squash;

  // Next fetch address: the target uses the PC = instruction + 8 convention.
  // All arithmetic wraps modulo 2^32.
  always_comb begin
    pc_next = pc + PC_INC;
    if (take_branch) begin
      pc_next = ir_pc + 32'd8 + bv_in;
    end
  end

  // Fetch PC and the decode-stage pipeline register.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values no matter what order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      ir     <= '0;
      ir_pc  <= RESET_PC;
      squash <= 1'b0;
    end else if (advance) begin
      pc     <= pc_next;
      ir     <= imem_rdata_in;
      ir_pc  <= pc;
      squash <= take_branch;
    end
  end

  assign imem_addr_out = pc;
  assign iin_out       = ir;
  assign ispb_out      = squash;
  assign pc_out        = ir_pc + 32'd8;
  assign link_we_out   = take_branch & bl_in;
  assign link_val_out  = ir_pc + 32'd4;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_branch;

  // Count every advancing edge and every honoured taken branch. Both wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch  <= '0;
      perf_branch <= '0;
    end else if (advance) begin
      perf_fetch <= perf_fetch + 32'd1;
      if (take_branch) begin
        perf_branch <= perf_branch + 32'd1;
      end
    end
  end

  assign perf_fetch_out  = perf_fetch;
  assign perf_branch_out = perf_branch;
`else
  assign perf_fetch_out  = '0;
  assign perf_branch_out = '0;
`endif

endmodule
